// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pll_reset_sequencer
// Brief    : PLL reset/lock qualifier with staggered domain reset release.
// Revision : 1.0
// ============================================================================
module pll_reset_sequencer #(
    parameter int NDOMAINS     = 4,
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_STABLE  = 1024,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int STAGGER      = 8
) (
    input  logic                clkin,
    input  logic                rstn,
    input  logic                pll_locked,
    input  logic                req,
    output logic                pll_rst,
    output logic [NDOMAINS-1:0] domain_rst,
    output logic                ready,
    output logic [7:0]          retry_count,
    output logic [2:0]          state
);

    localparam logic [2:0] c_ST_RESET_PLL = 3'd0;
    localparam logic [2:0] c_ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] c_ST_STABLE    = 3'd2;
    localparam logic [2:0] c_ST_RELEASE   = 3'd3;
    localparam logic [2:0] c_ST_RUN       = 3'd4;

    localparam int c_MAX_A = (RST_CYCLES > LOCK_STABLE) ? RST_CYCLES : LOCK_STABLE;
    localparam int c_MAX_B = (LOCK_TIMEOUT > STAGGER) ? LOCK_TIMEOUT : STAGGER;
    localparam int c_MAX   = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
    localparam int CW      = $clog2(c_MAX + 1);

    localparam logic [CW-1:0] c_ONE      = CW'(1);
    localparam logic [CW-1:0] c_RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] c_LS_LAST  = CW'(LOCK_STABLE - 1);
    localparam logic [CW-1:0] c_TO_LAST  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] c_STG_LAST = CW'(STAGGER - 1);

    logic [1:0]          r_sync;
    logic [2:0]          r_state;
    logic [CW-1:0]       r_cnt;
    logic [NDOMAINS-1:0] r_dr;
    logic                r_pll_rst;
    logic                r_ready;
    logic [7:0]          r_retry;

    logic                w_locked_s;
    logic [NDOMAINS-1:0] w_dr_shift;
    logic [2:0]          w_state_nxt;
    logic [CW-1:0]       w_cnt_nxt;
    logic [NDOMAINS-1:0] w_dr_nxt;
    logic                w_pll_rst_nxt;
    logic                w_ready_nxt;
    logic [7:0]          w_retry_nxt;
    logic                w_fault;
    logic                w_advance;

    assign w_locked_s = r_sync[1];
    // Bit 0 is released first, so each release step shifts a zero in from the bottom.
    assign w_dr_shift = r_dr << 1;

    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], pll_locked};
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt + c_ONE;
        w_dr_nxt      = r_dr;
        w_pll_rst_nxt = r_pll_rst;
        w_ready_nxt   = r_ready;
        w_fault       = 1'b0;
        w_advance     = 1'b0;

        case (r_state)
            c_ST_RESET_PLL: begin
                if (r_cnt == c_RST_LAST) begin
                    w_state_nxt   = c_ST_WAIT_LOCK;
                    w_cnt_nxt     = '0;
                    w_pll_rst_nxt = 1'b0;
                end
            end
            c_ST_WAIT_LOCK: begin
                // The sample that leaves WAIT_LOCK is the first of the stable run.
                if (w_locked_s) begin
                    if (LOCK_STABLE == 1) begin
                        w_advance = 1'b1;
                    end else begin
                        w_state_nxt = c_ST_STABLE;
                        w_cnt_nxt   = c_ONE;
                    end
                end else if (r_cnt == c_TO_LAST) begin
                    w_fault = 1'b1;
                end
            end
            c_ST_STABLE: begin
                if (!w_locked_s) begin
                    w_state_nxt = c_ST_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_LS_LAST) begin
                    w_advance = 1'b1;
                end
            end
            c_ST_RELEASE: begin
                if (!w_locked_s) begin
                    w_fault = 1'b1;
                end else if (r_cnt == c_STG_LAST) begin
                    w_advance = 1'b1;
                end
            end
            c_ST_RUN: begin
                w_cnt_nxt = r_cnt;
                if (!w_locked_s) begin
                    w_fault = 1'b1;
                end
            end
            default: begin
                w_state_nxt   = c_ST_RESET_PLL;
                w_cnt_nxt     = '0;
                w_dr_nxt      = '1;
                w_pll_rst_nxt = 1'b1;
                w_ready_nxt   = 1'b0;
            end
        endcase

        if (w_advance) begin
            w_dr_nxt    = w_dr_shift;
            w_cnt_nxt   = '0;
            w_ready_nxt = (w_dr_shift == '0);
            w_state_nxt = (w_dr_shift == '0) ? c_ST_RUN : c_ST_RELEASE;
        end

        // A request coinciding with a fault still yields a single restart.
        if (w_fault || (req && (r_state != c_ST_RESET_PLL))) begin
            w_state_nxt   = c_ST_RESET_PLL;
            w_cnt_nxt     = '0;
            w_dr_nxt      = '1;
            w_pll_rst_nxt = 1'b1;
            w_ready_nxt   = 1'b0;
        end

        w_retry_nxt = (w_fault && (r_retry != 8'hFF)) ? (r_retry + 8'd1) : r_retry;
    end

    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            r_state   <= c_ST_RESET_PLL;
            r_cnt     <= '0;
            r_dr      <= '1;
            r_pll_rst <= 1'b1;
            r_ready   <= 1'b0;
            r_retry   <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_dr      <= w_dr_nxt;
            r_pll_rst <= w_pll_rst_nxt;
            r_ready   <= w_ready_nxt;
            r_retry   <= w_retry_nxt;
        end
    end

    assign pll_rst     = r_pll_rst;
    assign domain_rst  = r_dr;
    assign ready       = r_ready;
    assign retry_count = r_retry;
    assign state       = r_state;

endmodule
`default_nettype wire
